// File: rtl/mining_pkg.sv
// Shared miner/scanner definitions.
// Memory contract and scanner state encoding.
package mining_pkg;

  localparam int NUM_NONCES = 16;
  localparam int MEM_READ_LATENCY = 1;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } scan_state_t;

endpackage

// File: rtl/hash_result_scanner.sv
// Scans miner H0 results: first hit under target
// and minimum hash with its nonce.
module hash_result_scanner
  import mining_pkg::*;
#(
  parameter int NUM_NONCES = mining_pkg::NUM_NONCES,
  parameter int IDX_W =
    (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] result_addr,
  input  word_t       nonce_base,
  input  word_t       target,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  input  word_t       mem_read_data,
  output logic        busy,
  output logic        done,
  output logic        found,
  output word_t       found_nonce,
  output word_t       min_hash,
  output word_t       min_nonce
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NONCES - 1);

  scan_state_t state_q, state_d;
  logic accept;

  logic [15:0]      base_q;
  word_t            nonce_q;
  word_t            target_q;
  logic [IDX_W-1:0] issue_idx;
  logic             a_vld, d_vld;
  logic [IDX_W-1:0] a_idx, d_idx;
  word_t            k_nonce;

  assign mem_clk = clk;
  assign mem_we  = 1'b0;
  assign busy    = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign done    = (state_q == S_DONE);
  assign k_nonce = nonce_q + 32'(d_idx);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (NUM_NONCES == 1) ? S_DRAIN : S_FETCH;
        end
      end
      S_FETCH: if (issue_idx == LAST) state_d = S_DRAIN;
      S_DRAIN: if (d_vld && d_idx == LAST) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // a_* tags the address on the bus, d_* the word on read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q      <= '0;
      nonce_q     <= '0;
      target_q    <= '0;
      issue_idx   <= '0;
      a_vld       <= 1'b0;
      a_idx       <= '0;
      d_vld       <= 1'b0;
      d_idx       <= '0;
      mem_addr    <= '0;
      found       <= 1'b0;
      found_nonce <= '0;
      min_hash    <= '0;
      min_nonce   <= '0;
    end else begin
      d_vld <= a_vld;
      d_idx <= a_idx;
      a_vld <= 1'b0;
      if (accept) begin
        base_q      <= result_addr;
        nonce_q     <= nonce_base;
        target_q    <= target;
        mem_addr    <= result_addr;
        a_vld       <= 1'b1;
        a_idx       <= '0;
        issue_idx   <= IDX_W'(1);
        found       <= 1'b0;
        found_nonce <= '0;
        min_hash    <= '1;
        min_nonce   <= '0;
      end else begin
        if (state_q == S_FETCH) begin
          mem_addr  <= base_q + 16'(issue_idx);
          a_vld     <= 1'b1;
          a_idx     <= issue_idx;
          issue_idx <= issue_idx + IDX_W'(1);
        end
        if (d_vld) begin
          if (!found && mem_read_data < target_q) begin
            found       <= 1'b1;
            found_nonce <= k_nonce;
          end
          // word 0 seeds the minimum so an all-ones scan reports it
          if (d_idx == '0 || mem_read_data < min_hash) begin
            min_hash  <= mem_read_data;
            min_nonce <= k_nonce;
          end
        end
      end
    end
  end

endmodule
